// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int          FETCH_QUEUE_DEPTH = 4;
  localparam logic [31:0] BUBBLE_INSTR      = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode queue: ready/valid FIFO of {pc, instr} entries.
// A flush (branch redirect) drops all buffered entries and any concurrent push.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  fetch_entry_t      mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;

  logic              push_s;
  logic              pop_s;
  fetch_entry_t      head_s;

  // Handshake decode and head-entry output mux (zero bubble when empty).
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    out_pc    = 32'h0000_0000;
    out_instr = BUBBLE_INSTR;
    count     = count_r;
    head_s    = mem_r[rd_ptr_r];

    in_ready  = (count_r < DEPTH_C);
    out_valid = (count_r != {CW{1'b0}});
    push_s    = in_valid && in_ready && !flush;
    pop_s     = out_valid && out_ready && !flush;

    if (out_valid) begin
      out_pc    = head_s.pc;
      out_instr = head_s.instr;
    end else begin
      out_pc    = 32'h0000_0000;
      out_instr = BUBBLE_INSTR;
    end
  end

  // Pointer, occupancy and storage update; storage itself is never cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= '{pc: in_pc, instr: in_instr};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end

      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end

      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 4).
module tb_fetch_queue;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  fetch_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr_of(pc);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_pc    = 32'h0;
    in_instr = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; idle_in();
    #2;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_push(32'(i * 4));
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, in_ready); end
      step();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b exp=0", in_ready); end
    drive_push(32'h10);
    step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_refused_count got=%0d exp=4", count); end
    idle_in();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== instr_of(32'(i * 4))) begin
        errors++; $display("FAIL fill_pop[%0d] got v=%b pc=%h instr=%h exp pc=%h", i, out_valid, out_pc, out_instr, 32'(i * 4));
      end
      step();
    end
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin
      errors++; $display("FAIL fill_drained got count=%0d v=%b pc=%h exp 0/0/0", count, out_valid, out_pc);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drive_push(32'h1000 + 32'(4 * c));
      if (c == 0) begin
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
          errors++; $display("FAIL stream_first got v=%b count=%0d exp v=0 count=0", out_valid, count);
        end
      end else begin
        exp_pc = 32'h1000 + 32'(4 * (c - 1));
        checks++; if (out_valid !== 1'b1 || count !== 3'd1 || out_pc !== exp_pc) begin
          errors++; $display("FAIL stream[%0d] got v=%b count=%0d pc=%h exp v=1 count=1 pc=%h", c, out_valid, count, out_pc, exp_pc);
        end
      end
      step();
    end
    idle_in();
    checks++; if (out_pc !== 32'h104C) begin errors++; $display("FAIL stream_last got=%h exp=104c", out_pc); end
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_drain got=%0d exp=0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(32'h200 + 32'(4 * i));
      step();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
    flush = 1'b1;
    drive_push(32'h100);
    step();
    flush = 1'b0;
    idle_in();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin
      errors++; $display("FAIL flush_after got count=%0d v=%b pc=%h exp 0/0/0", count, out_valid, out_pc);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b0 || out_pc === 32'h100) begin
        errors++; $display("FAIL flush_no_ghost[%0d] got v=%b pc=%h exp v=0", i, out_valid, out_pc);
      end
      step();
    end
    out_ready = 1'b0;
    drive_push(32'h300);
    step();
    idle_in();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300) begin
      errors++; $display("FAIL flush_repush got v=%b pc=%h exp v=1 pc=300", out_valid, out_pc);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    out_ready = 1'b0;
    drive_push(32'h400); step();
    drive_push(32'h404); step();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive_push(32'h408 + 32'(4 * k));
      exp_pc = 32'h400 + 32'(4 * k);
      checks++; if (out_pc !== exp_pc || out_instr !== instr_of(exp_pc) || count !== 3'd2) begin
        errors++; $display("FAIL wrap[%0d] got pc=%h count=%0d exp pc=%h count=2", k, out_pc, count, exp_pc);
      end
      step();
    end
    idle_in();
    for (int k = 10; k < 12; k++) begin
      exp_pc = 32'h400 + 32'(4 * k);
      checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
        errors++; $display("FAIL wrap_drain[%0d] got v=%b pc=%h exp pc=%h", k, out_valid, out_pc, exp_pc);
      end
      step();
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_empty got=%0d exp=0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_push(32'h500 + 32'(4 * i));
      step();
    end
    drive_push(32'h510);
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0 || out_pc !== 32'h500) begin
      errors++; $display("FAIL fullpop_pre got rdy=%b pc=%h exp rdy=0 pc=500", in_ready, out_pc);
    end
    step();
    idle_in();
    checks++; if (count !== 3'd3 || in_ready !== 1'b1 || out_pc !== 32'h504) begin
      errors++; $display("FAIL fullpop_post got count=%0d rdy=%b pc=%h exp 3/1/504", count, in_ready, out_pc);
    end
    for (int i = 1; i < 4; i++) begin
      checks++; if (out_pc !== 32'h500 + 32'(4 * i)) begin
        errors++; $display("FAIL fullpop_drain[%0d] got=%h exp=%h", i, out_pc, 32'h500 + 32'(4 * i));
      end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_no_510 got v=%b pc=%h exp v=0", out_valid, out_pc); end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(32'h600 + 32'(4 * i));
      step();
    end
    idle_in();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL arst_pre got=%0d exp=3", count); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0) begin
      errors++; $display("FAIL arst_async got count=%0d v=%b rdy=%b instr=%h exp 0/0/1/0", count, out_valid, in_ready, out_instr);
    end
    step();
    rst_n = 1'b1;
    drive_push(32'h700);
    step();
    idle_in();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h700 || dut.mem_r[0].pc !== 32'h700) begin
      errors++; $display("FAIL arst_slot0 got v=%b pc=%h slot0=%h exp pc=700", out_valid, out_pc, dut.mem_r[0].pc);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_streaming();
    test_flush();
    test_wrap();
    test_full_pop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered fetch entries; power of two, >= 2.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port flush  input  1  discard all buffered entries (branch redirect).
REQ-005 Port in_valid  input  1  fetch stage presents an entry.
REQ-006 Port in_ready  output  1  queue accepts an entry this cycle.
REQ-007 Port in_pc  input  32  PC of presented instruction.
REQ-008 Port in_instr  input  32  presented instruction word.
REQ-009 Port out_valid  output  1  head entry available to decode.
REQ-010 Port out_ready  input  1  decode consumes head this cycle.
REQ-011 Port out_pc  output  32  PC of head entry.
REQ-012 Port out_instr  output  32  instruction of head entry.
REQ-013 Port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-014 Push occurs on a rising edge when in_valid && in_ready && !flush; entry written at write pointer, write pointer increments.
REQ-015 Pop occurs on a rising edge when out_valid && out_ready && !flush; read pointer increments.
REQ-016 Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without extra logic.
REQ-017 count increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop.
REQ-018 in_ready = (count < DEPTH); no same-cycle pass-through when full, even if out_ready is high.
REQ-019 out_valid = (count != 0); out_pc/out_instr read combinationally from the head register.
REQ-020 When empty, out_pc and out_instr are 32'h0 (decode sees a zero bubble).
REQ-021 Latency: an entry pushed on edge N is visible on out_* after edge N, i.e. one cycle in_valid to out_valid when previously empty.
REQ-022 flush has priority over push and pop: on an edge with flush high, both pointers and count go to 0 and any concurrent push is dropped.
REQ-023 out_valid is 0 in the cycle after a flush edge regardless of in_valid during the flush cycle.
REQ-024 Entries are delivered strictly in push order; no entry is duplicated or lost except by flush.
REQ-025 Simultaneous push and pop with 0 < count < DEPTH keeps count constant and advances both pointers.
REQ-026 Storage contents are not cleared by pop or flush; only pointers/count define validity.

Reset
REQ-027 On rst_n low, asynchronously: pointers = 0, count = 0, out_valid = 0, in_ready = 1, out_pc = out_instr = 32'h0.
REQ-028 Reset asserted mid-operation discards all entries immediately; first push after rst_n deasserts lands in slot 0.
REQ-029 Storage array needs no reset.

Structure
REQ-030 Shared package fetch_pkg holds: fetch_entry_t packed struct {pc[31:0], instr[31:0]}, FETCH_QUEUE_DEPTH default constant (4), BUBBLE_INSTR constant 32'h0.
REQ-031 Storage is an array of fetch_entry_t inside the module; no sub-module is required.
REQ-032 All state updates are in one always_ff with async reset; ready/valid/output muxing in always_comb.

Verification
REQ-033 Reset: hold rst_n=0 mid-stream with count=3 -> count=0, out_valid=0, in_ready=1, out_instr=0 without a clock edge.
REQ-034 Fill: push PCs 0x0,0x4,0x8,0xC with out_ready=0 -> count=4, in_ready=0; fifth push (PC 0x10) is refused, and popping then yields 0x0,0x4,0x8,0xC in order.
REQ-035 Streaming: in_valid=out_ready=1 for 20 cycles from empty with PC stepping by 4 -> count settles at 1, out_pc lags in_pc by exactly one cycle, no gaps.
REQ-036 Flush: count=3, flush=1 with in_valid=1 (PC 0x100) -> next cycle count=0, out_valid=0; PC 0x100 never appears at out_pc.
REQ-037 Wrap: 10 push/pop cycles with DEPTH=4 -> pointers wrap twice, order preserved, count never exceeds 4.
REQ-038 Full with pop: count=4, out_ready=1, in_valid=1 -> pop occurs, push refused that cycle, count=3, in_ready=1 next cycle.
